// File: rtl/stream4_receiver_if.sv
// rtl/stream4_receiver_if.sv - handshake bundle between sender, receiver buffer and consumer
interface stream4_receiver_if #(
  parameter int P = 8
);
  logic         valid;
  logic [P-1:0] data;
  logic         ack;
  logic         out_valid;
  logic [P-1:0] out_data;
  logic         out_ready;

  // Sender and consumer side (drives offers and takes head words)
  modport master (
    output valid, data, out_ready,
    input  ack, out_valid, out_data
  );

  // Receiver side
  modport slave (
    input  valid, data, out_ready,
    output ack, out_valid, out_data
  );
endinterface

// File: rtl/stream4_receiver.sv
// rtl/stream4_receiver.sv - buffered stream receiver with incrementing-sequence checker
module stream4_receiver #(
  parameter int P     = 8,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  stream4_receiver_if.slave    bus,
  output logic                 seq_err,
  output logic [7:0]           err_count,
  output logic [15:0]          rx_count
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE = 1'b0, TRACK = 1'b1} seq_state_t;

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [P-1:0] mem [DEPTH];
  logic         full;
  logic         empty;
  logic         push;
  logic         pop;

  seq_state_t   state;
  seq_state_t   state_next;
  logic [P-1:0] expected;
  logic [P-1:0] expected_next;
  logic         mismatch;

  // Pointers carry one extra lap bit: equal pointers mean empty, equal index with
  // differing lap bit means full.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // ack and out_valid depend only on registered pointers, never on valid/out_ready
  assign bus.ack       = ~full;
  assign bus.out_valid = ~empty;
  assign bus.out_data  = mem[rd_ptr[AW-1:0]];

  assign push = bus.valid & ~full;
  assign pop  = bus.out_ready & ~empty;

  // Buffer storage write; contents need no reset since empty masks them
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr[AW-1:0]] <= bus.data;
    end
  end

  // Read/write pointer update; reset wins over any same-edge push or pop
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Sequence checker state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      expected <= '0;
    end else begin
      state    <= state_next;
      expected <= expected_next;
    end
  end

  // Sequence checker next state: every accept reseeds expected from the received word
  always_comb begin
    state_next    = state;
    expected_next = expected;
    mismatch      = 1'b0;
    if (push) begin
      expected_next = bus.data + P'(1);
      state_next    = TRACK;
      unique case (state)
        IDLE:    mismatch = 1'b0;
        TRACK:   mismatch = (bus.data != expected);
        default: mismatch = 1'b0;
      endcase
    end
  end

  // Error flag, saturating error counter and wrapping accept counter
  always_ff @(posedge clk) begin
    if (rst) begin
      seq_err   <= 1'b0;
      err_count <= '0;
      rx_count  <= '0;
    end else begin
      if (push) rx_count <= rx_count + 16'd1;
      if (mismatch) begin
        seq_err <= 1'b1;
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
    end
  end
endmodule

// File: doc/stream4_receiver.md
STREAM4_RECEIVER -- requirements
Module: stream4_receiver

Interface
REQ-001 The block SHALL have parameter P, default 8, meaning data width in bits (1..32).
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning buffer entries (power of 2, >=2).
REQ-003 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, reset, synchronous and active-high.
REQ-005 Port valid, input, 1, the sender offers a word this cycle.
REQ-006 Port data, input, P, the offered word.
REQ-007 Port ack, output, 1, the receiver can accept a word this cycle.
REQ-008 Port out_valid, output, 1, the buffer head word is available.
REQ-009 Port out_data, output, P, the buffer head word.
REQ-010 Port out_ready, input, 1, the downstream consumer takes the head word.
REQ-011 Port seq_err, output, 1, sticky flag for a sequence violation.
REQ-012 Port err_count, output, 8, count of sequence violations.
REQ-013 Port rx_count, output, 16, count of accepted words.

Function
REQ-014 Accept event SHALL be valid=1 and ack=1 at a rising clk edge; data SHALL be written to the buffer tail on that edge.
REQ-015 ack SHALL equal NOT full, driven directly from registered occupancy with no combinational path from valid or out_ready.
REQ-016 Pop event SHALL be out_valid=1 and out_ready=1 at a rising edge; the head SHALL advance on that edge.
REQ-017 out_valid SHALL equal NOT empty; out_data SHALL be the head entry, stable while out_valid=1 and out_ready=0.
REQ-018 Latency SHALL be exactly 1 cycle: a word accepted at edge N is visible on out_data after edge N; there SHALL be no same-cycle bypass.
REQ-019 Simultaneous push and pop SHALL leave occupancy unchanged and preserve FIFO order.
REQ-020 When full, ack=0 and no write occurs; a pop while full SHALL raise ack on the next cycle.
REQ-021 When empty, out_valid=0 and no pop occurs regardless of out_ready.
REQ-022 Read and write pointers SHALL be log2(DEPTH)+1 bits and wrap modulo 2*DEPTH; full/empty SHALL be derived from the MSB and index comparison.
REQ-023 Sequence checker state machine: IDLE (no word seen since reset) and TRACK (holds expected value).
REQ-024 In IDLE, the first accept SHALL load expected = data+1 mod 2^P and enter TRACK; no error SHALL be raised.
REQ-025 In TRACK, each accept with data != expected SHALL set seq_err=1 and increment err_count.
REQ-026 In TRACK, every accept SHALL set expected = data+1 mod 2^P, so the checker resynchronises to the received value after an error.
REQ-027 err_count SHALL saturate at 255; seq_err SHALL stay 1 until reset.
REQ-028 rx_count SHALL increment on every accept and wrap from 65535 to 0.
REQ-029 Accepted words SHALL be buffered regardless of any sequence error.

Reset
REQ-030 When rst=1 at an edge, the block SHALL clear both pointers, empty the buffer, clear seq_err, err_count and rx_count, and enter IDLE.
REQ-031 After reset, outputs SHALL be ack=1, out_valid=0, seq_err=0, err_count=0 and rx_count=0; buffer contents are don't-care.
REQ-032 rst SHALL take priority over a simultaneous push or pop on the same edge; the word is dropped and not counted.
REQ-033 Reset mid-stream SHALL return the checker to IDLE, so the next word seeds the sequence.

Verification (P=8, DEPTH=4)
REQ-034 Stream 0x10,0x11,0x12 with valid=1, out_ready=1 -> out_data 0x10,0x11,0x12 each one cycle after accept; seq_err=0; rx_count=3.
REQ-035 out_ready=0, valid=1 for 6 cycles -> 4 words accepted, ack=0 from the 5th cycle on; raise out_ready for one cycle -> ack=1 on the next cycle.
REQ-036 Stream 0x05,0x06,0x09,0x0A -> seq_err=1 after the 0x09 accept, err_count=1, no error on 0x0A; all 4 words delivered in order.
REQ-037 Stream 0xFE,0xFF,0x00 -> no error (mod-256 wrap); then 0x7F -> err_count=1.
REQ-038 Assert rst while 2 words are buffered and valid=1 -> next cycle out_valid=0, ack=1, rx_count=0, seq_err=0; first post-reset word 0x40 raises no error.
REQ-039 Full buffer with push and pop on the same edge -> only the pop occurs (ack=0); next cycle occupancy=3 and ack=1.
